// File: rtl/accum_sequencer_if.sv
// accum_sequencer_if: AXI-Stream beat bundle (data, valid, ready, last) with master/slave views
interface accum_sequencer_if #(parameter int W = 64) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/accum_sequencer.sv
// accum_sequencer: gates N aligned correlator frames into the accumulator, then streams the result BRAM out
module accum_sequencer #(
  parameter int DATA_W       = 96,
  parameter int RES_W        = 64,
  parameter int ADDR_W       = 10,
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_areset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     cfg_num_frames,
  input  logic [ADDR_W:0]      cfg_frame_len,
  accum_sequencer_if.slave     s_axis,
  accum_sequencer_if.master    acc_axis,
  output logic                 acc_first_frame,
  output logic                 bram_ren,
  output logic [ADDR_W-1:0]    bram_raddr,
  input  logic [RES_W-1:0]     bram_rdata,
  accum_sequencer_if.master    m_axis,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     frames_done
);
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [ADDR_W:0] ONE = 1;
  typedef enum logic [2:0] {IDLE, SYNC, ACCUM, DRAIN, READOUT, DONE} state_t;
  logic clk, rst;
  state_t state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d, frames_q, frames_d;
  logic [ADDR_W:0] len_q, len_d, beat_q, beat_d, raddr_q, raddr_d;
  logic [DW-1:0] drain_q, drain_d;
  logic err_q, err_d, infl_q, infl_d, infl_last_q, infl_last_d;
  logic [RES_W:0] fifo_q [2];
  logic wp_q, wp_d, rp_q, rp_d;
  logic [1:0] cnt_q, cnt_d;
  logic acc_hs, gen_last, pop, head_last, issue;
  assign clk = s00_axis_aclk;
  assign rst = s00_axis_areset;
  assign gen_last = beat_q == len_q - ONE;
  assign acc_hs = state_q == ACCUM && s_axis.tvalid && acc_axis.tready;
  assign s_axis.tready = state_q == SYNC || (state_q == ACCUM && acc_axis.tready);
  assign acc_axis.tvalid = state_q == ACCUM && s_axis.tvalid;
  assign acc_axis.tdata = state_q == ACCUM ? s_axis.tdata : '0;
  assign acc_axis.tlast = state_q == ACCUM && gen_last;
  assign acc_first_frame = state_q == ACCUM && frames_q == '0;
  assign {head_last, m_axis.tdata} = fifo_q[rp_q];
  assign m_axis.tvalid = cnt_q != 2'd0;
  assign m_axis.tlast = head_last;
  assign pop = m_axis.tvalid && m_axis.tready;
  // occupancy counted after this cycle's pop keeps one read per cycle while never overfilling the FIFO
  assign issue = state_q == READOUT && raddr_q < len_q &&
                 ({1'b0, cnt_q} - {2'b0, pop} + {2'b0, infl_q}) < 3'd2;
  assign bram_ren = issue;
  assign bram_raddr = raddr_q[ADDR_W-1:0];
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign frame_err = err_q;
  assign frames_done = frames_q;
  always_comb begin
    state_d = state_q;
    num_d = num_q;
    len_d = len_q;
    frames_d = frames_q;
    err_d = err_q;
    beat_d = beat_q;
    drain_d = drain_q;
    raddr_d = raddr_q;
    infl_d = issue;
    infl_last_d = raddr_q == len_q - ONE;
    wp_d = wp_q ^ infl_q;
    rp_d = rp_q ^ pop;
    cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d = SYNC;
        num_d = cfg_num_frames == '0 ? CNT_W'(1) : cfg_num_frames;
        len_d = cfg_frame_len;
        frames_d = '0;
        err_d = 1'b0;
        beat_d = '0;
      end
      SYNC: if (s_axis.tvalid && s_axis.tlast) state_d = ACCUM;
      ACCUM: if (acc_hs) begin
        err_d = err_q | (s_axis.tlast != gen_last);
        beat_d = gen_last ? '0 : beat_q + ONE;
        if (gen_last) frames_d = frames_q + CNT_W'(1);
        if (gen_last && frames_q + CNT_W'(1) == num_q) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + DW'(1);
        raddr_d = '0;
        if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = READOUT;
      end
      READOUT: begin
        if (issue) raddr_d = raddr_q + ONE;
        if (pop && head_last) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      frames_d = frames_q;
      err_d = err_q;
      infl_d = 1'b0;
      cnt_d = '0;
      wp_d = 1'b0;
      rp_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q <= '0;
      len_q <= '0;
      frames_q <= '0;
      err_q <= 1'b0;
      beat_q <= '0;
      drain_q <= '0;
      raddr_q <= '0;
      infl_q <= 1'b0;
      infl_last_q <= 1'b0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      len_q <= len_d;
      frames_q <= frames_d;
      err_q <= err_d;
      beat_q <= beat_d;
      drain_q <= drain_d;
      raddr_q <= raddr_d;
      infl_q <= infl_d;
      infl_last_q <= infl_last_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      if (infl_q) fifo_q[wp_q] <= {infl_last_q, bram_rdata};
    end
  end
endmodule

// File: tb/tb_accum_sequencer.sv
// tb_accum_sequencer: directed self-checking bench for accum_sequencer
module tb_accum_sequencer;
  localparam int DATA_W = 96, RES_W = 64, ADDR_W = 10, CNT_W = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [CNT_W-1:0] cfg_n = '0;
  logic [ADDR_W:0] cfg_len = '0;
  logic acc_first, bram_ren, busy, done, frame_err;
  logic [ADDR_W-1:0] bram_raddr;
  logic [RES_W-1:0] bram_rdata;
  logic [CNT_W-1:0] frames_done;
  accum_sequencer_if #(.W(DATA_W)) s_if ();
  accum_sequencer_if #(.W(DATA_W)) acc_if ();
  accum_sequencer_if #(.W(RES_W)) m_if ();
  accum_sequencer dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .start(start), .abort(abort),
    .cfg_num_frames(cfg_n), .cfg_frame_len(cfg_len), .s_axis(s_if), .acc_axis(acc_if),
    .acc_first_frame(acc_first), .bram_ren(bram_ren), .bram_raddr(bram_raddr),
    .bram_rdata(bram_rdata), .m_axis(m_if), .busy(busy), .done(done),
    .frame_err(frame_err), .frames_done(frames_done)
  );
  always #5 clk = ~clk;
  function automatic logic [RES_W-1:0] bram_val(int a);
    return {32'hC0DE_0000 + a, 32'h5A5A_5A5A ^ a};
  endfunction
  always @(posedge clk) bram_rdata <= bram_ren ? bram_val(int'(bram_raddr)) : 64'hBAD0_BAD0_BAD0_BAD0;
  int checks = 0, errors = 0;
  logic [DATA_W-1:0] src_d[$];
  logic src_l[$];
  int src_i = 0;
  logic s_fire = 1'b0, acc_toggle = 1'b0;
  int stall_at = 0, stall_left = 0;
  int cyc = 0, acc_cnt, first_cnt, m_cnt, done_cnt, prot_err, first_mv, last_acc_cyc;
  logic [DATA_W-1:0] acc_dq[$];
  int tl_q[$], rd_q[$];
  logic [RES_W-1:0] m_dq[$];
  logic m_lq[$];
  logic prev_mv = 1'b0, prev_mr = 1'b0, prev_ml = 1'b0;
  logic [RES_W-1:0] prev_md = '0;
  task automatic check(string tag, logic [DATA_W-1:0] got, logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(posedge clk); #1;
    if (s_fire) src_i++;
    s_if.tvalid = src_i < src_d.size();
    if (s_if.tvalid) begin
      s_if.tdata = src_d[src_i];
      s_if.tlast = src_l[src_i];
    end else begin
      s_if.tdata = '0;
      s_if.tlast = 1'b0;
    end
    acc_if.tready = acc_toggle ? !acc_if.tready : 1'b1;
    if (stall_left > 0 && m_cnt >= stall_at) begin
      m_if.tready = 1'b0;
      stall_left--;
    end else m_if.tready = 1'b1;
  end
  initial forever begin
    @(negedge clk);
    cyc++;
    s_fire = s_if.tvalid && s_if.tready;
    if (acc_if.tvalid && acc_if.tready) begin
      acc_cnt++;
      acc_dq.push_back(acc_if.tdata);
      if (acc_first) first_cnt++;
      if (acc_if.tlast) tl_q.push_back(acc_cnt);
      last_acc_cyc = cyc;
    end
    if (bram_ren) rd_q.push_back(int'(bram_raddr));
    if (m_if.tvalid && first_mv < 0) first_mv = cyc;
    if (prev_mv && !prev_mr && (!m_if.tvalid || m_if.tdata !== prev_md || m_if.tlast !== prev_ml)) prot_err++;
    prev_mv = m_if.tvalid;
    prev_mr = m_if.tready;
    prev_md = m_if.tdata;
    prev_ml = m_if.tlast;
    if (m_if.tvalid && m_if.tready) begin
      m_cnt++;
      m_dq.push_back(m_if.tdata);
      m_lq.push_back(m_if.tlast);
    end
    if (done) done_cnt++;
  end
  task automatic tick();
    @(posedge clk); #2;
  endtask
  task automatic mon_clear();
    acc_cnt = 0; first_cnt = 0; m_cnt = 0; done_cnt = 0; prot_err = 0; first_mv = -1; last_acc_cyc = 0;
    acc_dq.delete(); tl_q.delete(); rd_q.delete(); m_dq.delete(); m_lq.delete();
  endtask
  task automatic src_clear();
    src_d.delete(); src_l.delete(); src_i = 0;
  endtask
  task automatic src_push(logic [DATA_W-1:0] d, logic l);
    src_d.push_back(d); src_l.push_back(l);
  endtask
  task automatic do_start(int len, int n);
    cfg_len = (ADDR_W+1)'(len); cfg_n = CNT_W'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(int lim);
    int n = 0;
    while (done_cnt == 0 && n < lim) begin tick(); n++; end
    check("done_seen", done_cnt > 0, 1);
    tick();
  endtask
  task automatic check_readout(string tag, int len);
    check({tag, "_reads"}, rd_q.size(), len);
    foreach (rd_q[k]) check({tag, "_raddr"}, rd_q[k], k);
    check({tag, "_mbeats"}, m_cnt, len);
    foreach (m_dq[k]) begin
      check({tag, "_mdata"}, m_dq[k], bram_val(k));
      check({tag, "_mlast"}, m_lq[k], k == len - 1);
    end
  endtask
  task automatic load_4x3();
    src_clear();
    src_push(96'hBAD_0001, 1'b0);
    src_push(96'hBAD_0002, 1'b1);
    for (int k = 0; k < 12; k++) src_push(96'(100 + k), k % 4 == 3);
  endtask
  task automatic check_4x3(string tag);
    check({tag, "_acc_n"}, acc_cnt, 12);
    foreach (acc_dq[k]) check({tag, "_acc_data"}, acc_dq[k], 96'(100 + k));
    check({tag, "_first_n"}, first_cnt, 4);
    check({tag, "_tlast_n"}, tl_q.size(), 3);
    foreach (tl_q[k]) check({tag, "_tlast_pos"}, tl_q[k], 4 * (k + 1));
    check({tag, "_frames"}, frames_done, 3);
    check({tag, "_err"}, frame_err, 0);
    check({tag, "_done_n"}, done_cnt, 1);
    check({tag, "_busy"}, busy, 0);
    check_readout(tag, 4);
  endtask
  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    acc_if.tready = 1'b1; m_if.tready = 1'b1;
    mon_clear();
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frames", frames_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_s_ready", s_if.tready, 0);
    check("rst_acc_valid", acc_if.tvalid, 0);
    check("rst_m_valid", m_if.tvalid, 0);
    check("rst_ren", bram_ren, 0);
    tick();
    rst = 1'b0;
    tick();
    // 1: clean run, 4-beat frames, 3 frames
    mon_clear(); load_4x3();
    do_start(4, 3);
    check("t1_busy", busy, 1);
    wait_done(300);
    check_4x3("t1");
    check("t1_latency", first_mv - last_acc_cyc, 11);
    // 2: accumulator back-pressure and a result-stream stall
    mon_clear(); load_4x3();
    acc_toggle = 1'b1; stall_at = 2; stall_left = 5;
    do_start(4, 3);
    wait_done(400);
    acc_toggle = 1'b0;
    check_4x3("t2");
    check("t2_m_stable", prot_err, 0);
    // 3: upstream tlast misplaced in frame 1
    mon_clear(); src_clear();
    src_push(96'hBAD_0003, 1'b1);
    for (int k = 0; k < 8; k++) src_push(96'(200 + k), k == 3 || k == 6);
    do_start(4, 2);
    wait_done(300);
    check("t3_err", frame_err, 1);
    check("t3_tlast_n", tl_q.size(), 2);
    foreach (tl_q[k]) check("t3_tlast_pos", tl_q[k], 4 * (k + 1));
    check("t3_frames", frames_done, 2);
    repeat (3) tick();
    check("t3_err_sticky", frame_err, 1);
    // 4: cfg_num_frames=0 runs one frame and clears the sticky error
    mon_clear(); src_clear();
    src_push(96'hBAD_0004, 1'b1);
    for (int k = 0; k < 4; k++) src_push(96'(300 + k), k % 2 == 1);
    do_start(2, 0);
    check("t4_err_clr", frame_err, 0);
    check("t4_frames_clr", frames_done, 0);
    wait_done(300);
    check("t4_acc_n", acc_cnt, 2);
    check("t4_frames", frames_done, 1);
    check("t4_consumed", src_i, 3);
    check_readout("t4", 2);
    // frame_len=1: every beat is a frame
    mon_clear(); src_clear();
    src_push(96'hBAD_0005, 1'b1);
    for (int k = 0; k < 3; k++) src_push(96'(400 + k), 1'b1);
    do_start(1, 3);
    wait_done(300);
    check("l1_tlast_n", tl_q.size(), 3);
    foreach (tl_q[k]) check("l1_tlast_pos", tl_q[k], k + 1);
    check("l1_first_n", first_cnt, 1);
    check("l1_frames", frames_done, 3);
    check("l1_err", frame_err, 0);
    check_readout("l1", 1);
    // 5: abort during readout after 2 of 8 beats
    mon_clear(); src_clear();
    src_push(96'hBAD_0006, 1'b1);
    for (int k = 0; k < 8; k++) src_push(96'(500 + k), k == 7);
    stall_at = 2; stall_left = 40;
    do_start(8, 1);
    for (int n = 0; n < 300 && m_cnt < 2; n++) tick();
    check("t5_two_beats", m_cnt, 2);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_m_valid", m_if.tvalid, 0);
    check("t5_ren", bram_ren, 0);
    tick();
    stall_left = 0;
    repeat (3) tick();
    check("t5_no_done", done_cnt, 0);
    check("t5_m_n", m_cnt, 2);
    check("t5_frames", frames_done, 1);
    mon_clear(); src_clear();
    src_push(96'hBAD_0007, 1'b1);
    for (int k = 0; k < 2; k++) src_push(96'(600 + k), k == 1);
    do_start(2, 1);
    check("t5_restart_busy", busy, 1);
    wait_done(300);
    check_readout("t5r", 2);
    // 6: abort+start in IDLE, and start while busy
    mon_clear(); src_clear();
    cfg_len = 11'd4; cfg_n = 16'd1; abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("t6_abort_start", busy, 0);
    tick();
    src_push(96'hBAD_0008, 1'b1);
    for (int k = 0; k < 2; k++) src_push(96'(700 + k), k == 1);
    do_start(2, 1);
    tick();
    do_start(4, 5);
    wait_done(300);
    check("t6_frames", frames_done, 1);
    check("t6_acc_n", acc_cnt, 2);
    check_readout("t6", 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
Controls one averaging run of the channel-sounder accumulator. It aligns to the correlator frame stream and gates N whole frames into the accumulator, marking the first frame so the accumulator overwrites instead of adding. It then reads the result BRAM out as a 64-bit AXI-Stream frame and pulses done. It sits between the correlator output, the accumulator and the result DMA path.

Parameters:
DATA_W, 96, width of the correlator/accumulator stream beat.
RES_W, 64, result BRAM word width.
ADDR_W, 10, result BRAM address width; maximum frame is 2**ADDR_W beats.
CNT_W, 16, width of the frame counter.
DRAIN_CYCLES, 8, wait between the last accepted beat and the first BRAM read; covers the accumulator write pipeline.

Ports:
s00_axis_aclk  in  1  single clock for all logic.
s00_axis_areset  in  1  reset, synchronous, active-high.
start  in  1  one-cycle pulse; accepted only in IDLE.
abort  in  1  level; returns the block to IDLE.
cfg_num_frames  in  CNT_W  frames to average; 0 is treated as 1. Sampled at start.
cfg_frame_len  in  ADDR_W+1  beats per frame, 1..2**ADDR_W. Sampled at start.
s_axis_tdata/tvalid/tlast  in  DATA_W/1/1  correlator stream.
s_axis_tready  out  1  ready to the correlator stream.
acc_axis_tdata/tvalid/tlast  out  DATA_W/1/1  stream to the accumulator.
acc_axis_tready  in  1  accumulator ready.
acc_first_frame  out  1  high for every beat of frame 0.
bram_ren / bram_raddr  out  1/ADDR_W  result BRAM read port.
bram_rdata  in  RES_W  read data; valid exactly 1 cycle after bram_ren.
m_axis_tdata/tvalid/tlast  out  RES_W/1/1  result stream.
m_axis_tready  in  1  result stream ready.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when a run completes.
frame_err  out  1  sticky; cleared at accepted start.
frames_done  out  CNT_W  frames accumulated in the current or last run.

Behaviour:
- Reset: state IDLE; every output 0; counters and output buffer cleared.
- States: IDLE, SYNC, ACCUM, DRAIN, READOUT, DONE.
- IDLE: s_axis_tready=0. On start, latch cfg, clear frames_done and frame_err, go to SYNC. start in any other state is ignored.
- SYNC: s_axis_tready=1 and acc_axis_tvalid=0, so upstream beats are discarded. A handshake with tlast=1 moves to ACCUM on the next cycle.
- ACCUM:
  - Combinational pass-through: acc_axis_tvalid=s_axis_tvalid, s_axis_tready=acc_axis_tready, tdata forwarded unchanged.
  - A beat counter advances on each acc handshake.
  - acc_axis_tlast is generated from the counter, high when beat==frame_len-1. Upstream tlast is only checked, never forwarded.
  - If upstream tlast differs from the generated tlast on any handshake, set frame_err. The frame still counts.
  - acc_first_frame = (frames_done==0).
  - On a handshake with generated tlast: frames_done++ and the beat counter resets. If frames_done reaches N, go to DRAIN; the ready/valid gating drops in that same next cycle.
- DRAIN: s_axis_tready=0. Wait DRAIN_CYCLES cycles, then go to READOUT.
- READOUT:
  - Read addresses 0..frame_len-1 in order.
  - A 2-entry output FIFO feeds m_axis. A read issues only when FIFO occupancy + reads in flight < 2, so no data is lost under back-pressure.
  - With m_axis_tready held high, throughput is 1 beat/cycle and the first m_axis_tvalid appears 2 cycles after READOUT entry.
  - m_axis_tlast is high on the beat from address frame_len-1.
  - After that beat's handshake, go to DONE.
- m_axis protocol: once tvalid is asserted, tdata and tlast stay stable until the handshake.
- DONE: done=1 for one cycle, then IDLE. frames_done and frame_err hold their values.
- frame_len=1: every beat is a whole frame with tlast=1; readout is a single beat.
- abort (any state except IDLE): next cycle in IDLE.
  - All valids and readies go to 0, the FIFO is flushed and in-flight reads are discarded.
  - No done pulse. frames_done and frame_err are held.
- Reset mid-run: same as abort, and also clears frames_done and frame_err.
- abort and start in the same cycle: abort wins and start is dropped.

Test Plan:
1. frame_len=4, N=3, upstream sends 2 junk beats ending in tlast, then 12 clean beats, m_axis_tready=1 -> junk not forwarded; acc_first_frame high on exactly 4 beats; acc tlast on beats 4/8/12; frames_done=3; 4 reads at addr 0..3; m_axis tlast on 4th beat; done 1 cycle; frame_err=0.
2. Same as 1, with acc_axis_tready toggling every other cycle and m_axis_tready low for 5 cycles mid-readout -> no beat lost or duplicated; m_axis data matches a BRAM model at addr 0..3 in order.
3. frame_len=4, N=2, upstream tlast on beat 3 of frame 1 -> frame_err=1 and sticky after done; acc tlast still on counts 4 and 8; cleared at next start.
4. cfg_num_frames=0 -> exactly one frame accumulated; frames_done=1.
5. abort during READOUT after 2 of 8 beats -> IDLE next cycle; m_axis_tvalid=0; no done; start accepted immediately after.
6. start pulsed while busy, and abort+start in the same IDLE cycle -> both starts ignored; a later start begins a clean run.
